// File: rtl/matrix_packet_buffer_if.sv
// Command/response bus between the HPS-FPGA bridge and the matrix packet buffer.
interface matrix_packet_buffer_if #(
    parameter int unsigned PKT_W = 32,
    parameter int unsigned SEL_W = 1,
    parameter int unsigned OFF_W = 3
) ();
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [SEL_W-1:0] cmd_sel;
    logic [OFF_W-1:0] cmd_offset;
    logic [PKT_W-1:0] pkt_data_in;
    logic [PKT_W-1:0] pkt_data_out;
    logic             done;
    logic             err;

    // Bridge side: issues commands, receives completion and load data.
    modport master (
        output cmd_valid, cmd_op, cmd_sel, cmd_offset, pkt_data_in,
        input  cmd_ready, pkt_data_out, done, err
    );

    // Buffer side.
    modport slave (
        input  cmd_valid, cmd_op, cmd_sel, cmd_offset, pkt_data_in,
        output cmd_ready, pkt_data_out, done, err
    );
endinterface

// File: rtl/matrix_packet_buffer.sv
// Packet buffer: assembles source matrices from packets for the coprocessor and
// returns a snapshot of the coprocessor result as packets.
module matrix_packet_buffer #(
    parameter int unsigned PKT_W  = 32,
    parameter int unsigned ELEM_W = 8,
    parameter int unsigned DIM    = 5,
    parameter int unsigned N_SRC  = 2,
    localparam int unsigned MAT_W = ELEM_W * DIM * DIM,
    localparam int unsigned N_PKT = (MAT_W + PKT_W - 1) / PKT_W,
    localparam int unsigned OFF_W = (N_PKT > 1) ? $clog2(N_PKT) : 1,
    localparam int unsigned SEL_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    matrix_packet_buffer_if.slave    bus,
    output logic [N_SRC*MAT_W-1:0]   matrices,
    input  logic                     coproc_busy,
    input  logic                     coproc_done,
    input  logic [MAT_W-1:0]         result_in
);

    // Bits of the matrix carried by the (possibly partial) last packet.
    localparam int unsigned LAST_W = MAT_W - (N_PKT - 1) * PKT_W;
    localparam int unsigned SELC_W = SEL_W + 1;
    localparam int unsigned OFFC_W = OFF_W + 1;

    localparam logic [1:0] OP_STORE      = 2'b00;
    localparam logic [1:0] OP_STORE_NEXT = 2'b01;
    localparam logic [1:0] OP_LOAD       = 2'b10;
    localparam logic [1:0] OP_CLEAR      = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e           state_q;
    logic             ready_q;
    logic             done_q;
    logic             err_q;
    logic [PKT_W-1:0] dout_q;

    logic [1:0]       op_q;
    logic [SEL_W-1:0] sel_q;
    logic [OFF_W-1:0] off_q;
    logic [PKT_W-1:0] data_q;

    logic [MAT_W-1:0] mat_q [N_SRC];
    logic [OFF_W-1:0] ptr_q [N_SRC];
    logic [MAT_W-1:0] res_q;

    logic             sel_ok;
    logic             off_ok;
    logic [SEL_W-1:0] sel_idx;
    logic [OFF_W-1:0] wr_off;
    logic [OFF_W-1:0] ptr_inc;
    logic [MAT_W-1:0] wr_mat;
    logic [PKT_W-1:0] ld_pkt;
    logic             cmd_err;

    assign bus.cmd_ready    = ready_q;
    assign bus.done         = done_q;
    assign bus.err          = err_q;
    assign bus.pkt_data_out = dout_q;

    // Source matrices are exposed straight from their registers.
    for (genvar k = 0; k < N_SRC; k++) begin : g_mat_out
        assign matrices[k*MAT_W +: MAT_W] = mat_q[k];
    end

    // Range checks, packet merge for stores, packet extraction for loads, error decode.
    always_comb begin
        sel_ok  = ({1'b0, sel_q} < SELC_W'(N_SRC));
        off_ok  = ({1'b0, off_q} < OFFC_W'(N_PKT));
        sel_idx = sel_ok ? sel_q : '0;
        wr_off  = (op_q == OP_STORE_NEXT) ? ptr_q[sel_idx] : off_q;
        ptr_inc = (ptr_q[sel_idx] == OFF_W'(N_PKT - 1)) ? '0 : ptr_q[sel_idx] + OFF_W'(1);

        wr_mat = mat_q[sel_idx];
        for (int unsigned p = 0; p < N_PKT - 1; p++) begin
            if (wr_off == OFF_W'(p)) begin
                wr_mat[MAT_W-1-p*PKT_W -: PKT_W] = data_q;
            end
        end
        if (wr_off == OFF_W'(N_PKT - 1)) begin
            wr_mat[LAST_W-1:0] = data_q[PKT_W-1 -: LAST_W];
        end

        ld_pkt = '0;
        for (int unsigned p = 0; p < N_PKT - 1; p++) begin
            if (off_q == OFF_W'(p)) begin
                ld_pkt = res_q[MAT_W-1-p*PKT_W -: PKT_W];
            end
        end
        if (off_q == OFF_W'(N_PKT - 1)) begin
            ld_pkt[PKT_W-1 -: LAST_W] = res_q[LAST_W-1:0];
        end

        cmd_err = 1'b0;
        case (op_q)
            OP_STORE:      cmd_err = !sel_ok || !off_ok || coproc_busy;
            OP_STORE_NEXT: cmd_err = !sel_ok || coproc_busy;
            OP_LOAD:       cmd_err = !off_ok;
            OP_CLEAR:      cmd_err = !sel_ok || coproc_busy;
            default:       cmd_err = 1'b1;
        endcase
    end

    // Command FSM, matrix/pointer storage and result shadow capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            dout_q  <= '0;
            op_q    <= OP_STORE;
            sel_q   <= '0;
            off_q   <= '0;
            data_q  <= '0;
            res_q   <= '0;
            for (int unsigned k = 0; k < N_SRC; k++) begin
                mat_q[k] <= '0;
                ptr_q[k] <= '0;
            end
        end else begin
            // A LOAD in EXEC on this edge still sees the old shadow value.
            if (coproc_done) begin
                res_q <= result_in;
            end

            case (state_q)
                ST_IDLE: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    if (ready_q && bus.cmd_valid) begin
                        op_q    <= bus.cmd_op;
                        sel_q   <= bus.cmd_sel;
                        off_q   <= bus.cmd_offset;
                        data_q  <= bus.pkt_data_in;
                        ready_q <= 1'b0;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    err_q   <= cmd_err;
                    done_q  <= 1'b1;
                    state_q <= ST_RESP;
                    if (!cmd_err) begin
                        case (op_q)
                            OP_STORE: begin
                                mat_q[sel_idx] <= wr_mat;
                            end
                            OP_STORE_NEXT: begin
                                mat_q[sel_idx] <= wr_mat;
                                ptr_q[sel_idx] <= ptr_inc;
                            end
                            OP_LOAD: begin
                                dout_q <= ld_pkt;
                            end
                            default: begin
                                mat_q[sel_idx] <= '0;
                                ptr_q[sel_idx] <= '0;
                            end
                        endcase
                    end
                end
                ST_RESP: begin
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    ready_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_packet_buffer.sv
// Scoreboard bench for matrix_packet_buffer with hand-computed directed vectors.
module tb_matrix_packet_buffer;

    localparam int unsigned PKT_W = 32;
    localparam int unsigned MAT_W = 200;
    localparam int unsigned N_SRC = 2;

    localparam logic [1:0] OP_STORE      = 2'b00;
    localparam logic [1:0] OP_STORE_NEXT = 2'b01;
    localparam logic [1:0] OP_LOAD       = 2'b10;
    localparam logic [1:0] OP_CLEAR      = 2'b11;

    localparam logic [199:0] M0_INIT = 200'h11111111_22222222_33333333_44444444_55555555_66666666_77;
    localparam logic [199:0] M1_SN   = 200'hA7A7A7A7_A1A1A1A1_A2A2A2A2_A3A3A3A3_A4A4A4A4_A5A5A5A5_A6;
    localparam logic [199:0] M1_B0   = 200'hA7A7A7A7_B0B0B0B0_A2A2A2A2_A3A3A3A3_A4A4A4A4_A5A5A5A5_A6;
    localparam logic [199:0] M1_C0   = 200'hA7A7A7A7_B0B0B0B0_C0C0C0C0_A3A3A3A3_A4A4A4A4_A5A5A5A5_A6;
    localparam logic [199:0] M1_55   = 200'h55555555_00000000_00000000_00000000_00000000_00000000_00;
    localparam logic [199:0] RES1    = 200'h12345678_9ABCDEF0_0FEDCBA9_87654321_DEADBEEF_CAFEF00D_5A;
    localparam logic [199:0] RES2    = {25{8'hC3}};

    typedef struct {
        logic        err;
        logic [31:0] dout;
        int          done_cyc;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic coproc_busy = 1'b0;
    logic coproc_done = 1'b0;
    logic [MAT_W-1:0] result_in = '0;
    logic [N_SRC*MAT_W-1:0] matrices;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    exp_t sb[$];

    matrix_packet_buffer_if #(.PKT_W(PKT_W), .SEL_W(1), .OFF_W(3)) bus ();

    matrix_packet_buffer #(.PKT_W(32), .ELEM_W(8), .DIM(5), .N_SRC(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .matrices    (matrices),
        .coproc_busy (coproc_busy),
        .coproc_done (coproc_done),
        .result_in   (result_in)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [399:0] act, input logic [399:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 400'(1), 400'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_err"},  400'(bus.err), 400'(e.err));
                chk({e.name, "_dout"}, 400'(bus.pkt_data_out), 400'(e.dout));
                chk({e.name, "_lat"},  400'(cyc), 400'(e.done_cyc));
            end
        end
    end

    // Issue one command and wait (bounded) for its response to be retired.
    task automatic issue(input logic [1:0] op, input logic sel, input logic [2:0] off,
                         input logic [31:0] data, input logic exp_err, input logic [31:0] exp_dout,
                         input string name, input logic cap_on_exec = 1'b0,
                         input logic [199:0] cap_val = '0);
        int n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!bus.cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cmd_ready) begin
            chk({name, "_ready_timeout"}, 400'(0), 400'(1));
            return;
        end
        bus.cmd_valid   = 1'b1;
        bus.cmd_op      = op;
        bus.cmd_sel     = sel;
        bus.cmd_offset  = off;
        bus.pkt_data_in = data;
        e.err = exp_err;
        e.dout = exp_dout;
        e.done_cyc = cyc + 2;
        e.name = name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.cmd_valid   = 1'b0;
        bus.pkt_data_in = 32'hDEADDEAD;
        if (cap_on_exec) begin
            coproc_done = 1'b1;
            result_in   = cap_val;
            @(posedge clk);
            #1;
            coproc_done = 1'b0;
        end
        n = 0;
        while (sb.size() != 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk({name, "_done_timeout"}, 400'(0), 400'(1));
            sb.delete();
        end
    endtask

    task automatic chk_mats(input string name, input logic [199:0] m0, input logic [199:0] m1);
        @(negedge clk);
        chk({name, "_m0"}, 400'(matrices[199:0]), 400'(m0));
        chk({name, "_m1"}, 400'(matrices[399:200]), 400'(m1));
    endtask

    initial begin
        bus.cmd_valid   = 1'b0;
        bus.cmd_op      = 2'b00;
        bus.cmd_sel     = 1'b0;
        bus.cmd_offset  = 3'd0;
        bus.pkt_data_in = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", 400'(bus.cmd_ready), 400'(0));
        chk("rst_done",  400'(bus.done), 400'(0));
        chk("rst_err",   400'(bus.err), 400'(0));
        chk("rst_dout",  400'(bus.pkt_data_out), 400'(0));
        chk("rst_mats",  400'(matrices), 400'(0));
        rst_n = 1'b1;
        #1;
        chk("rel_ready_low", 400'(bus.cmd_ready), 400'(0));
        @(negedge clk);
        chk("rel_ready_high", 400'(bus.cmd_ready), 400'(1));

        // Random-access stores into matrix 0
        for (int p = 0; p < 7; p++) begin
            issue(OP_STORE, 1'b0, 3'(p), 32'h11111111 * 32'(p + 1), 1'b0, 32'h0, "store0");
        end
        chk_mats("store0", M0_INIT, 200'h0);

        // Auto-increment stores into matrix 1, wrapping once
        for (int i = 0; i < 8; i++) begin
            issue(OP_STORE_NEXT, 1'b1, 3'd0, 32'hA0A0A0A0 + 32'h01010101 * 32'(i), 1'b0, 32'h0, "snext");
        end
        chk_mats("snext", M0_INIT, M1_SN);
        issue(OP_STORE_NEXT, 1'b1, 3'd5, 32'hB0B0B0B0, 1'b0, 32'h0, "snext_wrap");
        chk_mats("snext_wrap", M0_INIT, M1_B0);

        // Result capture and loads, including the partial last packet
        @(negedge clk);
        result_in = RES1;
        coproc_done = 1'b1;
        @(negedge clk);
        coproc_done = 1'b0;
        result_in = '0;
        issue(OP_LOAD, 1'b0, 3'd6, 32'h0, 1'b0, 32'h5A000000, "load6");
        issue(OP_LOAD, 1'b1, 3'd0, 32'h0, 1'b0, 32'h12345678, "load0");
        issue(OP_LOAD, 1'b0, 3'd3, 32'h0, 1'b0, 32'h87654321, "load3");

        // Out-of-range offsets
        issue(OP_STORE, 1'b0, 3'd7, 32'hFFFFFFFF, 1'b1, 32'h87654321, "store_off7");
        issue(OP_LOAD,  1'b0, 3'd7, 32'h0,        1'b1, 32'h87654321, "load_off7");
        chk_mats("range_err", M0_INIT, M1_B0);

        // Lock while the coprocessor is busy; loads still serviced
        coproc_busy = 1'b1;
        issue(OP_STORE,      1'b0, 3'd0, 32'hEEEEEEEE, 1'b1, 32'h87654321, "busy_store");
        issue(OP_CLEAR,      1'b1, 3'd0, 32'h0,        1'b1, 32'h87654321, "busy_clear");
        issue(OP_STORE_NEXT, 1'b1, 3'd0, 32'hEEEEEEEE, 1'b1, 32'h87654321, "busy_snext");
        issue(OP_LOAD,       1'b0, 3'd1, 32'h0,        1'b0, 32'h9ABCDEF0, "busy_load");
        chk_mats("busy", M0_INIT, M1_B0);
        coproc_busy = 1'b0;

        // Pointer did not move under busy
        issue(OP_STORE_NEXT, 1'b1, 3'd0, 32'hC0C0C0C0, 1'b0, 32'h9ABCDEF0, "snext_after_busy");
        chk_mats("snext_after_busy", M0_INIT, M1_C0);

        // Capture coinciding with LOAD EXEC returns the previous shadow
        issue(OP_LOAD, 1'b0, 3'd2, 32'h0, 1'b0, 32'h0FEDCBA9, "load_cap", 1'b1, RES2);
        issue(OP_LOAD, 1'b0, 3'd2, 32'h0, 1'b0, 32'hC3C3C3C3, "load_new");

        // Clear resets both contents and pointer
        issue(OP_CLEAR, 1'b1, 3'd4, 32'h0, 1'b0, 32'hC3C3C3C3, "clear1");
        chk_mats("clear1", M0_INIT, 200'h0);
        issue(OP_STORE_NEXT, 1'b1, 3'd3, 32'h55555555, 1'b0, 32'hC3C3C3C3, "snext_after_clear");
        chk_mats("snext_after_clear", M0_INIT, M1_55);

        // Reset during EXEC aborts with no done pulse
        @(negedge clk);
        bus.cmd_valid   = 1'b1;
        bus.cmd_op      = OP_STORE;
        bus.cmd_sel     = 1'b0;
        bus.cmd_offset  = 3'd0;
        bus.pkt_data_in = 32'hDEAD0000;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("abort_done", 400'(bus.done), 400'(0));
        end
        chk("abort_ready", 400'(bus.cmd_ready), 400'(0));
        chk("abort_err",   400'(bus.err), 400'(0));
        chk("abort_dout",  400'(bus.pkt_data_out), 400'(0));
        chk("abort_mats",  400'(matrices), 400'(0));
        rst_n = 1'b1;
        #1;
        chk("abort_rel_ready_low", 400'(bus.cmd_ready), 400'(0));
        @(negedge clk);
        chk("abort_rel_ready_high", 400'(bus.cmd_ready), 400'(1));
        issue(OP_LOAD, 1'b0, 3'd0, 32'h0, 1'b0, 32'h0, "load_after_rst");

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
